// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer (start, data LSB first, optional parity, 1/2 stop bits) paced by a baud strobe.
// Define UART_TX_PARITY_EN to build the parity stage; otherwise ParityType is ignored.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  BaudTick,
    input  logic                  Send,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic [1:0]            ParityType,
    input  logic                  StopBits,
    output logic                  DataTx,
    output logic                  Busy,
    output logic                  Done
);
    localparam int CW = $clog2(DATA_WIDTH);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP1, STOP2} state_t;
    logic r_par_en;
    logic r_par_bit;
`else
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP1, STOP2} state_t;
    logic w_unused;
    assign w_unused = ^ParityType;
`endif
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_stop2;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_last;
    assign w_last = r_cnt == CW'(DATA_WIDTH - 1);
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_stop2 <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (Send) begin
                    r_state <= ARM;
                    r_busy  <= 1'b1;
                    r_shift <= DataIn;
                    r_stop2 <= StopBits;
`ifdef UART_TX_PARITY_EN
                    r_par_en  <= ^ParityType;
                    r_par_bit <= (ParityType == 2'b01) ? ~^DataIn : ^DataIn;
`endif
                end
                // ARM aligns the start bit to a tick so it lasts a full bit period
                ARM: if (BaudTick) begin
                    r_state <= START;
                    r_tx    <= 1'b0;
                end
                START: if (BaudTick) begin
                    r_state <= DATA;
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_cnt   <= '0;
                end
                DATA: if (BaudTick) begin
                    if (!w_last) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        r_state <= r_par_en ? PARITY : STOP1;
                        r_tx    <= r_par_en ? r_par_bit : 1'b1;
`else
                        r_state <= STOP1;
                        r_tx    <= 1'b1;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (BaudTick) begin
                    r_state <= STOP1;
                    r_tx    <= 1'b1;
                end
`endif
                STOP1: if (BaudTick) begin
                    r_state <= r_stop2 ? STOP2 : IDLE;
                    r_busy  <= r_stop2;
                    r_done  <= ~r_stop2;
                end
                STOP2: if (BaudTick) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
    assign DataTx = r_tx;
    assign Busy   = r_busy;
    assign Done   = r_done;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame, baud strobe every 16 clocks, 8 data bits.
module tb_uart_tx_frame;
    logic       Clock = 1'b0;
    logic       ResetN = 1'b0;
    logic       Send = 1'b0;
    logic       StopBits = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic [1:0] ParityType = 2'b00;
    logic       BaudTick;
    logic       DataTx;
    logic       Busy;
    logic       Done;
    logic [3:0] tick_cnt = 4'h0;
    int         done_cnt = 0;
    int         checks = 0;
    int         fails = 0;
    int         d0;
    int         w;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .Clock(Clock), .ResetN(ResetN), .BaudTick(BaudTick), .Send(Send),
        .DataIn(DataIn), .ParityType(ParityType), .StopBits(StopBits),
        .DataTx(DataTx), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) tick_cnt <= tick_cnt + 4'h1;
    assign BaudTick = tick_cnt == 4'hF;
    always @(posedge Clock) if (Done) done_cnt <= done_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] pt, input logic sb);
        DataIn = d;
        ParityType = pt;
        StopBits = sb;
        Send = 1'b1;
        @(negedge Clock);
        Send = 1'b0;
        DataIn = ~d;
        ParityType = ~pt;
        StopBits = ~sb;
    endtask

    // Samples each line bit mid-period; ends on the negedge where Done is visible.
    task automatic frame(input string tag, input int n, input logic [11:0] exp,
                         input int glitch, input int exp_wait);
        logic [11:0] obs;
        int wt;
        int dc;
        obs = '0;
        wt = 0;
        dc = done_cnt;
        chk({tag, "_busy"}, 32'(Busy), 1);
        while (DataTx !== 1'b0 && wt < 40) begin
            @(negedge Clock);
            wt++;
        end
        chk({tag, "_start_seen"}, 32'(wt < 40), 1);
        if (wt >= 40) return;
        if (exp_wait >= 0) chk({tag, "_start_latency"}, 32'(wt), 32'(exp_wait));
        for (int i = 0; i < n; i++) begin
            repeat (8) @(negedge Clock);
            obs[i] = DataTx;
            if (i == glitch) begin
                DataIn = 8'hFF;
                Send = 1'b1;
                @(negedge Clock);
                Send = 1'b0;
                repeat (7) @(negedge Clock);
            end else begin
                repeat (8) @(negedge Clock);
            end
        end
        chk({tag, "_bits"}, 32'(obs), 32'(exp));
        chk({tag, "_done"}, 32'(Done), 1);
        chk({tag, "_busy_end"}, 32'(Busy), 0);
        chk({tag, "_line_end"}, 32'(DataTx), 1);
        chk({tag, "_no_early_done"}, 32'(done_cnt - dc), 0);
    endtask

    initial begin
        repeat (3) @(negedge Clock);
        chk("rst_tx", 32'(DataTx), 1);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        ResetN = 1'b1;
        repeat (5) @(negedge Clock);
        chk("idle_tick_busy", 32'(Busy), 0);

        d0 = done_cnt;
        send(8'hA5, 2'b00, 1'b0);
        frame("8n1_a5", 10, {2'b00, 1'b1, 8'hA5, 1'b0}, -1, -1);
        repeat (20) @(negedge Clock);
        chk("8n1_one_done", 32'(done_cnt - d0), 1);
        chk("8n1_idle_busy", 32'(Busy), 0);

`ifdef UART_TX_PARITY_EN
        send(8'hA5, 2'b10, 1'b0);
        frame("even_a5", 11, {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, -1, -1);
        repeat (5) @(negedge Clock);
        send(8'hA5, 2'b01, 1'b0);
        frame("odd_a5", 11, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, -1, -1);
        repeat (5) @(negedge Clock);
        send(8'h07, 2'b10, 1'b0);
        frame("even_07", 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, -1, -1);
        repeat (5) @(negedge Clock);
`else
        send(8'hA5, 2'b01, 1'b0);
        frame("nopar_a5", 10, {2'b00, 1'b1, 8'hA5, 1'b0}, -1, -1);
        repeat (5) @(negedge Clock);
`endif

        send(8'h3C, 2'b00, 1'b1);
        frame("8n2_3c", 11, {1'b0, 2'b11, 8'h3C, 1'b0}, -1, -1);
        repeat (5) @(negedge Clock);

        d0 = done_cnt;
        send(8'h55, 2'b00, 1'b0);
        frame("busy_ign_55", 10, {2'b00, 1'b1, 8'h55, 1'b0}, 3, -1);
        repeat (60) @(negedge Clock);
        chk("busy_ign_one_done", 32'(done_cnt - d0), 1);
        chk("busy_ign_line", 32'(DataTx), 1);
        chk("busy_ign_idle", 32'(Busy), 0);

        d0 = done_cnt;
        send(8'h00, 2'b00, 1'b0);
        w = 0;
        while (DataTx !== 1'b0 && w < 40) begin
            @(negedge Clock);
            w++;
        end
        chk("rst_mid_start_seen", 32'(w < 40), 1);
        repeat (16 * 4 + 8) @(negedge Clock);
        chk("rst_mid_bit3", 32'(DataTx), 0);
        ResetN = 1'b0;
        @(negedge Clock);
        ResetN = 1'b1;
        chk("rst_mid_tx", 32'(DataTx), 1);
        chk("rst_mid_busy", 32'(Busy), 0);
        chk("rst_mid_done", 32'(Done), 0);
        repeat (120) @(negedge Clock);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 0);
        chk("rst_mid_line", 32'(DataTx), 1);
        send(8'hC3, 2'b00, 1'b0);
        frame("after_rst_c3", 10, {2'b00, 1'b1, 8'hC3, 1'b0}, -1, -1);
        repeat (5) @(negedge Clock);

        d0 = done_cnt;
        send(8'h34, 2'b00, 1'b0);
        frame("b2b_34", 10, {2'b00, 1'b1, 8'h34, 1'b0}, -1, -1);
        send(8'h12, 2'b00, 1'b0);
        frame("b2b_12", 10, {2'b00, 1'b1, 8'h12, 1'b0}, -1, 15);
        @(negedge Clock);
        chk("b2b_two_done", 32'(done_cnt - d0), 2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
